serial_add_1007: RTL and testbench

SERIAL_ADD_1007 -- requirements
Module: serial_add_1007

---
 rtl/serial_add_1007.sv | 154 +++++++++++++++
 tb/tb_serial_add_1007.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_1007.sv
// serial_add_1007: bit-serial adder that produces one result bit per SHIFT cycle, LSB first.
// Defining SERIAL_ADD_1007_OVF_EN adds the two's-complement overflow output ovf.
module serial_add_1007 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_1007_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cy_q, cy_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             hs_w;
  logic             bit_w;
  logic             carry_w;
  logic [WIDTH-1:0] shift_w;

`ifdef SERIAL_ADD_1007_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  // Full adder built from two half adders and an OR.
  always_comb begin
    hs_w    = a_q[0] ^ b_q[0];
    bit_w   = hs_w ^ cy_q;
    carry_w = (a_q[0] & b_q[0]) | (cy_q & hs_w);
    // res_q holds the WIDTH-1 bits already produced; the new bit lands on top.
    shift_w = {bit_w, res_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cy_d    = cy_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADD_1007_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          res_d   = '0;
          cy_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef SERIAL_ADD_1007_OVF_EN
          a_msb_d = a_in[WIDTH-1];
          b_msb_d = b_in[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cy_d  = carry_w;
        res_d = shift_w[WIDTH-1:1];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = shift_w;
          cout_d  = carry_w;
          state_d = DONE;
`ifdef SERIAL_ADD_1007_OVF_EN
          ovf_d   = (a_msb_q == b_msb_q) && (bit_w != a_msb_q);
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cy_q    <= cy_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SERIAL_ADD_1007_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_1007.sv
// Scoreboard bench for serial_add_1007 (WIDTH=8): latency, results, busy/done exclusivity,
// start-ignore while busy, mid-operation reset, and back-to-back starts.
module tb_serial_add_1007;

  localparam int unsigned W   = 8;
  localparam int          LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_1007_OVF_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  serial_add_1007 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_1007_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] t;
    exp_t e;
    t   = {1'b0, a} + {1'b0, b};
    e.s = t[W-1:0];
    e.c = t[W];
    e.v = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return e;
  endfunction

  // Drives a one-cycle start and records the expected result; returns at the
  // first negedge after the accepting edge.
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    sb.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for done; lat counts sampled cycles after the accepting edge.
  task automatic wait_done(output int lat, output int busy_n, output int overlap);
    lat     = 1;
    busy_n  = 0;
    overlap = 0;
    while (done !== 1'b1 && lat < 4 * LAT) begin
      if (busy === 1'b1) busy_n++;
      if (busy === 1'b1 && done === 1'b1) overlap++;
      @(negedge clk);
      lat++;
    end
    if (busy === 1'b1 && done === 1'b1) overlap++;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, sum, cout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b, want all 0", busy, done, sum, cout);
    end
`ifdef SERIAL_ADD_1007_OVF_EN
    vectors++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b want 0", ovf);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_add(input logic [W-1:0] a, input logic [W-1:0] b);
    int   lat, busy_n, overlap;
    exp_t e;
    drive_start(a, b);
    wait_done(lat, busy_n, overlap);
    vectors++;
    if (lat !== LAT || busy_n !== W || overlap !== 0) begin
      errors++;
      $display("FAIL add_timing %h+%h: got lat=%0d busy=%0d overlap=%0d, want lat=%0d busy=%0d overlap=0",
               a, b, lat, busy_n, overlap, LAT, W);
    end
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    vectors++;
    if (sum !== e.s || cout !== e.c) begin
      errors++;
      $display("FAIL add_result %h+%h: got sum=%h cout=%b, want sum=%h cout=%b", a, b, sum, cout, e.s, e.c);
    end
`ifdef SERIAL_ADD_1007_OVF_EN
    vectors++;
    if (ovf !== e.v) begin
      errors++;
      $display("FAIL add_ovf %h+%h: got %b want %b", a, b, ovf, e.v);
    end
`endif
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== e.s) begin
      errors++;
      $display("FAIL add_after %h+%h: got done=%b busy=%b sum=%h, want done=0 busy=0 sum=%h",
               a, b, done, busy, sum, e.s);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      test_add(W'($urandom), W'($urandom));
    end
  endtask

  task automatic test_busy_ignore();
    int   lat, busy_n, overlap, extra;
    exp_t e;
    drive_start(8'h3C, 8'h41);
    repeat (2) @(negedge clk);
    a_in  = 8'hAA;
    b_in  = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in  = 8'hF0;
    wait_done(lat, busy_n, overlap);
    vectors++;
    if (lat + 3 !== LAT || overlap !== 0) begin
      errors++;
      $display("FAIL ignore_timing: got lat=%0d overlap=%0d, want lat=%0d overlap=0", lat + 3, overlap, LAT);
    end
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    vectors++;
    if (sum !== e.s || cout !== e.c) begin
      errors++;
      $display("FAIL ignore_result: got sum=%h cout=%b, want sum=%h cout=%b", sum, cout, e.s, e.c);
    end
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL ignore_no_queue: got %0d busy/done cycles after result, want 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int   lat, busy_n, overlap, seen;
    exp_t e;
    drive_start(8'hC3, 8'h5A);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({busy, done, sum, cout} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b sum=%h cout=%b, want all 0", busy, done, sum, cout);
    end
    sb.delete();
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    rst = 1'b0;
    vectors++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d done pulses, want 0", seen);
    end
    drive_start(8'h10, 8'h20);
    wait_done(lat, busy_n, overlap);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    vectors++;
    if (lat !== LAT || sum !== 8'h30 || sum !== e.s || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_recover: got lat=%0d sum=%h cout=%b, want lat=%0d sum=30 cout=0", lat, sum, cout, LAT);
    end
  endtask

  task automatic test_back_to_back();
    int   n_done, first, gap_bad, last, busy_rst, overlap;
    exp_t e;
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    a_in  = 8'h96;
    b_in  = 8'h6B;
    busy_rst = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy === 1'b1 || done === 1'b1) busy_rst++;
    end
    vectors++;
    if (busy_rst !== 0) begin
      errors++;
      $display("FAIL start_during_rst: got %0d active cycles, want 0", busy_rst);
    end
    for (int i = 0; i < 3; i++) sb.push_back(model(8'h96, 8'h6B));
    rst     = 1'b0;
    n_done  = 0;
    first   = -1;
    last    = 0;
    gap_bad = 0;
    overlap = 0;
    for (int idx = 1; idx <= 32; idx++) begin
      @(negedge clk);
      if (busy === 1'b1 && done === 1'b1) overlap++;
      if (done === 1'b1) begin
        n_done++;
        if (first < 0) first = idx;
        else if (idx - last != LAT + 1) gap_bad++;
        last = idx;
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        vectors++;
        if (sum !== e.s || cout !== e.c) begin
          errors++;
          $display("FAIL b2b_result: got sum=%h cout=%b, want sum=%h cout=%b", sum, cout, e.s, e.c);
        end
      end
    end
    start = 1'b0;
    vectors++;
    if (n_done !== 3 || first !== LAT || gap_bad !== 0 || overlap !== 0) begin
      errors++;
      $display("FAIL b2b_timing: got dones=%0d first=%0d bad_gaps=%0d overlap=%0d, want 3/%0d/0/0",
               n_done, first, gap_bad, overlap, LAT);
    end
    repeat (2 * LAT) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add(8'h05, 8'h03);
    test_add(8'hFF, 8'h01);
    test_add(8'h7F, 8'h01);
    test_add(8'h80, 8'h80);
    test_random();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
